// File: rtl/mem_moc_ram_if.sv
// Memory request/response bus between the control unit (master) and the
// byte-addressed memory (slave): MOV/RW/typeData/Address/DataIn request
// signals out, DataOut/MOC response back.
interface mem_moc_ram_if;
  logic        MOV;
  logic        RW;
  logic        typeData;
  logic [31:0] Address;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        MOC;

  modport master (
    output MOV, RW, typeData, Address, DataIn,
    input  DataOut, MOC
  );

  modport slave (
    input  MOV, RW, typeData, Address, DataIn,
    output DataOut, MOC
  );
endinterface

// File: rtl/mem_moc_ram.sv
// Byte-addressed big-endian memory with a MOV/MOC handshake and a
// programmable number of wait states before the access completes.
// Word and byte transfers; word addresses are rounded down to a 4-byte
// boundary and all addresses wrap modulo DEPTH.
module mem_moc_ram #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic          CLK,
  input  logic          CLR,
  mem_moc_ram_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  // One count above LATENCY so the access edge itself is part of the wait,
  // giving MOC LATENCY+2 edges after the accepting edge.
  localparam logic [4:0] CNT_LOAD = 5'(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state_q, state_d;
  logic [4:0]     cnt_q, cnt_d;
  logic           moc_q, moc_d;
  logic [31:0]    dout_q, dout_d;
  logic           rw_q, rw_d;
  logic           byte_q, byte_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [31:0]    din_q, din_d;

  logic [7:0]     mem [DEPTH];
  logic [AW-1:0]  a0, a1, a2, a3;
  logic           access;
  logic           we;
  logic           unused_addr_hi;

  assign unused_addr_hi = ^bus.Address[31:AW];

  // Byte lanes of the latched request; word accesses ignore the low two bits.
  always_comb begin
    a0 = byte_q ? addr_q : {addr_q[AW-1:2], 2'b00};
    a1 = a0 + AW'(1);
    a2 = a0 + AW'(2);
    a3 = a0 + AW'(3);
  end

  // The access happens on the last BUSY edge; a reset on that edge cancels the write.
  assign access = (state_q == BUSY) && (cnt_q == 5'd0);
  assign we     = access && !rw_q && !CLR;

  // Next-state, wait counter, request latch and read-data selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    moc_d   = 1'b0;
    dout_d  = dout_q;
    rw_d    = rw_q;
    byte_d  = byte_q;
    addr_d  = addr_q;
    din_d   = din_q;
    case (state_q)
      IDLE: begin
        if (bus.MOV) begin
          rw_d    = bus.RW;
          byte_d  = bus.typeData;
          addr_d  = bus.Address[AW-1:0];
          din_d   = bus.DataIn;
          cnt_d   = CNT_LOAD;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 5'd0) begin
          cnt_d = cnt_q - 5'd1;
        end else begin
          state_d = DONE;
          moc_d   = 1'b1;
          if (rw_q) begin
            dout_d = byte_q ? {24'b0, mem[a0]} : {mem[a0], mem[a1], mem[a2], mem[a3]};
          end
        end
      end
      DONE: begin
        if (bus.MOV) begin
          moc_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and response registers, cleared by CLR.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      moc_q   <= 1'b0;
      dout_q  <= 32'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      moc_q   <= moc_d;
      dout_q  <= dout_d;
    end
  end

  // Latched request fields; only meaningful while an access is in flight.
  always_ff @(posedge CLK) begin
    rw_q   <= rw_d;
    byte_q <= byte_d;
    addr_q <= addr_d;
    din_q  <= din_d;
  end

  // Big-endian write into the byte array; contents survive reset.
  always_ff @(posedge CLK) begin
    if (we) begin
      if (byte_q) begin
        mem[a0] <= din_q[7:0];
      end else begin
        mem[a0] <= din_q[31:24];
        mem[a1] <= din_q[23:16];
        mem[a2] <= din_q[15:8];
        mem[a3] <= din_q[7:0];
      end
    end
  end

  assign bus.MOC     = moc_q;
  assign bus.DataOut = dout_q;
endmodule
